alu_seq_ctrl: RTL and testbench
===============================

Name: alu_seq_ctrl

Overview:
- Sequencing controller in front of the 16-bit bit-sliced 74181-style ALU (alu_16bit).
- Accepts one command at a time over a valid/ready handshake and drives the ALU's a/b/s/m/cin inputs for as many cycles as the command needs.
- Returns the result over a valid/ready response channel.
- Supports native single-pass ALU functions, a 32-bit add built from two 16-bit passes, and an unsigned 16x16 shift-add multiply.

Parameters:
- ADD_S, 4'b1001, ALU select code for A PLUS B (used with m=0).
- CARRY_LOW, 1, 1 = alu_cin/alu_cout are active-low carries (TI convention); 0 = active-high. Applies only to ops 01/10.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  command valid
- in_ready  out  1  command accepted when in_valid&in_ready at a clk edge
- in_op  in  2  00 ALU pass, 01 ADD32, 10 MUL16, 11 reserved
- in_a  in  32  operand A (ops 00/10 use [15:0])
- in_b  in  32  operand B (ops 00/10 use [15:0])
- in_s  in  4  ALU select, op 00 only
- in_m  in  1  ALU mode, op 00 only
- in_cin  in  1  raw ALU carry-in, op 00 only
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed when rsp_valid&rsp_ready at a clk edge
- rsp_res  out  32  result; op 00 gives {16'h0, alu_o}
- rsp_cout  out  1  op 00: raw alu_cout; op 01: true carry-out (active-high); op 10: 0
- rsp_err  out  1  reserved or unsupported op
- busy  out  1  state != IDLE
- alu_a, alu_b  out  16  to ALU
- alu_s  out  4  to ALU
- alu_m, alu_cin  out  1  to ALU
- alu_o  in  16  from ALU (combinational)
- alu_cout  in  1  from ALU

Behaviour:
- Reset, when rst_n=0 at an edge: state=IDLE; rsp_valid, rsp_res, rsp_cout, rsp_err, busy, counter, operand regs, alu_* all 0. Reset aborts any operation in progress; no response is produced for it.
- in_ready = (state==IDLE) & rst_n.
- alu_* are driven from registers and state. The ALU is combinational; its outputs are sampled at the edge that ends each state cycle.
- States: IDLE, EXEC, ADDL, ADDH, MUL, DONE.
- IDLE: on accept at edge k, latch operands and go to:
  - op 00 -> EXEC
  - op 01 -> ADDL
  - op 10 -> MUL (acc_hi=0, acc_lo=in_a[15:0], mcand=in_b[15:0], cnt=0)
  - op 11 -> DONE with rsp_err=1, rsp_res=0; rsp_valid high after edge k.
- EXEC:
  - Drive alu_a=a[15:0], alu_b=b[15:0], alu_s=in_s, alu_m=in_m, alu_cin=in_cin (all latched).
  - At edge k+1, capture alu_o and alu_cout, then go to DONE.
- ADDL:
  - Drive a[15:0], b[15:0], s=ADD_S, m=0, carry-in=0.
  - Capture the low result and the internal carry c (normalized to active-high), then go to ADDH.
- ADDH:
  - Drive a[31:16], b[31:16] with carry-in=c.
  - Capture the high result and the true carry-out, then go to DONE. rsp_valid is high after edge k+2.
  - 32-bit wrap: overflow is reported only through rsp_cout.
- MUL: each cycle drive alu_a=acc_hi, alu_b=mcand, add with carry-in=0.
  - sum17 = acc_lo[0] ? {carry, alu_o} : {1'b0, acc_hi}.
  - acc_hi <= sum17[16:1]; acc_lo <= {sum17[0], acc_lo[15:1]}; cnt++.
  - After 16 cycles (cnt==15 at the edge): rsp_res={acc_hi, acc_lo}, then go to DONE. rsp_valid is high after edge k+16.
- Carry normalization for ops 01/10: alu_cin = CARRY_LOW ? ~c : c; carry = CARRY_LOW ? ~alu_cout : alu_cout.
- DONE:
  - rsp_valid=1; rsp_res, rsp_cout and rsp_err are held stable while rsp_ready=0.
  - On rsp_valid&rsp_ready: rsp_valid, rsp_err <- 0 and state -> IDLE. A new command is accepted no earlier than the following edge (no same-cycle turnaround).
- Outside EXEC/ADDL/ADDH/MUL: alu_* hold their last values. Downstream must ignore alu_o in those states.

Optional Feature:
- Macro ALU_SEQ_MUL_EN.
- Defined: op 10 runs the MUL sequence as above.
- Undefined: MUL state and counter are not built; op 10 behaves as op 11 (DONE, rsp_err=1, rsp_res=0).

Test Plan:
- Bench connects alu_16bit with CARRY_LOW=1 for all scenarios.
- ADD32 basic: a=32'h0000FFFF, b=32'h00000001 -> rsp_res=32'h00010000, rsp_cout=0, rsp_valid 2 edges after accept.
- ADD32 wrap: a=32'hFFFFFFFF, b=1 -> rsp_res=0, rsp_cout=1.
- MUL16 (macro defined): a=16'hFFFF, b=16'hFFFF -> rsp_res=32'hFFFE0001, rsp_valid 16 edges after accept. a=16'h1234, b=0 -> 0.
- Op 00 backpressure: s=4'b0110, m=1 (A XOR B), a=16'h00FF, b=16'h0F0F -> rsp_res=32'h00000FF0. Hold rsp_ready=0 for 5 cycles; rsp_res stable and in_ready=0 throughout.
- Reserved op 11, and op 10 with macro undefined -> rsp_err=1, rsp_res=0. Next command accepted normally and reports rsp_err=0.
- Reset during MUL cycle 7: rsp_valid stays 0, busy=0 and in_ready=1 after release. A following ADD32 returns the correct result.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: sequences single-pass, ADD32 and MUL16 commands onto a
// 74181-style 16-bit ALU. MUL16 is built only when ALU_SEQ_MUL_EN is defined.
module alu_seq_ctrl #(
   parameter logic [3:0] ADD_S     = 4'b1001,
   parameter logic       CARRY_LOW = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  in_op,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   input  logic [3:0]  in_s,
   input  logic        in_m,
   input  logic        in_cin,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_res,
   output logic        rsp_cout,
   output logic        rsp_err,
   output logic        busy,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   output logic [3:0]  alu_s,
   output logic        alu_m,
   output logic        alu_cin,
   input  logic [15:0] alu_o,
   input  logic        alu_cout
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_EXEC = 3'd1;
   localparam logic [2:0] S_ADDL = 3'd2;
   localparam logic [2:0] S_ADDH = 3'd3;
   localparam logic [2:0] S_DONE = 3'd5;
`ifdef ALU_SEQ_MUL_EN
   localparam logic [2:0] S_MUL  = 3'd4;
`endif

   logic [2:0]  state_q, state_d;
   logic [15:0] ahi_q, ahi_d;
   logic [15:0] bhi_q, bhi_d;
   logic [15:0] alu_a_q, alu_a_d;
   logic [15:0] alu_b_q, alu_b_d;
   logic [3:0]  alu_s_q, alu_s_d;
   logic        alu_m_q, alu_m_d;
   logic        alu_cin_q, alu_cin_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_res_q, rsp_res_d;
   logic        rsp_cout_q, rsp_cout_d;
   logic        rsp_err_q, rsp_err_d;
`ifdef ALU_SEQ_MUL_EN
   logic [15:0] acc_hi_q, acc_hi_d;
   logic [15:0] acc_lo_q, acc_lo_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [16:0] sum17;
`endif

   // ALU carry-out seen as an active-high carry
   logic carry;
   assign carry = CARRY_LOW ? ~alu_cout : alu_cout;

   always_comb begin
      state_d     = state_q;
      ahi_d       = ahi_q;
      bhi_d       = bhi_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_s_d     = alu_s_q;
      alu_m_d     = alu_m_q;
      alu_cin_d   = alu_cin_q;
      rsp_valid_d = rsp_valid_q;
      rsp_res_d   = rsp_res_q;
      rsp_cout_d  = rsp_cout_q;
      rsp_err_d   = rsp_err_q;
`ifdef ALU_SEQ_MUL_EN
      acc_hi_d    = acc_hi_q;
      acc_lo_d    = acc_lo_q;
      cnt_d       = cnt_q;
      sum17       = 17'h0;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               ahi_d = in_a[31:16];
               bhi_d = in_b[31:16];
               unique case (in_op)
                  2'b00: begin
                     state_d   = S_EXEC;
                     alu_a_d   = in_a[15:0];
                     alu_b_d   = in_b[15:0];
                     alu_s_d   = in_s;
                     alu_m_d   = in_m;
                     alu_cin_d = in_cin;
                  end
                  2'b01: begin
                     state_d   = S_ADDL;
                     alu_a_d   = in_a[15:0];
                     alu_b_d   = in_b[15:0];
                     alu_s_d   = ADD_S;
                     alu_m_d   = 1'b0;
                     alu_cin_d = CARRY_LOW;
                  end
`ifdef ALU_SEQ_MUL_EN
                  2'b10: begin
                     state_d   = S_MUL;
                     acc_hi_d  = 16'h0;
                     acc_lo_d  = in_a[15:0];
                     cnt_d     = 4'd0;
                     alu_a_d   = 16'h0;
                     alu_b_d   = in_b[15:0];
                     alu_s_d   = ADD_S;
                     alu_m_d   = 1'b0;
                     alu_cin_d = CARRY_LOW;
                  end
`endif
                  default: begin
                     state_d     = S_DONE;
                     rsp_valid_d = 1'b1;
                     rsp_err_d   = 1'b1;
                     rsp_res_d   = 32'h0;
                     rsp_cout_d  = 1'b0;
                  end
               endcase
            end
         end
         S_EXEC: begin
            state_d     = S_DONE;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_res_d   = {16'h0, alu_o};
            rsp_cout_d  = alu_cout;
         end
         S_ADDL: begin
            state_d   = S_ADDH;
            rsp_res_d = {16'h0, alu_o};
            alu_a_d   = ahi_q;
            alu_b_d   = bhi_q;
            alu_cin_d = CARRY_LOW ? ~carry : carry;
         end
         S_ADDH: begin
            state_d         = S_DONE;
            rsp_valid_d     = 1'b1;
            rsp_err_d       = 1'b0;
            rsp_res_d[31:16] = alu_o;
            rsp_cout_d      = carry;
         end
`ifdef ALU_SEQ_MUL_EN
         S_MUL: begin
            // one shift-add step: add mcand when the multiplier LSB is set
            sum17    = acc_lo_q[0] ? {carry, alu_o} : {1'b0, acc_hi_q};
            acc_hi_d = sum17[16:1];
            acc_lo_d = {sum17[0], acc_lo_q[15:1]};
            cnt_d    = cnt_q + 4'd1;
            alu_a_d  = sum17[16:1];
            if (cnt_q == 4'd15) begin
               state_d     = S_DONE;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b0;
               rsp_cout_d  = 1'b0;
               rsp_res_d   = {sum17, acc_lo_q[15:1]};
            end
         end
`endif
         S_DONE: begin
            if (rsp_ready) begin
               state_d     = S_IDLE;
               rsp_valid_d = 1'b0;
               rsp_err_d   = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         ahi_q       <= 16'h0;
         bhi_q       <= 16'h0;
         alu_a_q     <= 16'h0;
         alu_b_q     <= 16'h0;
         alu_s_q     <= 4'h0;
         alu_m_q     <= 1'b0;
         alu_cin_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_res_q   <= 32'h0;
         rsp_cout_q  <= 1'b0;
         rsp_err_q   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
         acc_hi_q    <= 16'h0;
         acc_lo_q    <= 16'h0;
         cnt_q       <= 4'd0;
`endif
      end else begin
         state_q     <= state_d;
         ahi_q       <= ahi_d;
         bhi_q       <= bhi_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_s_q     <= alu_s_d;
         alu_m_q     <= alu_m_d;
         alu_cin_q   <= alu_cin_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_res_q   <= rsp_res_d;
         rsp_cout_q  <= rsp_cout_d;
         rsp_err_q   <= rsp_err_d;
`ifdef ALU_SEQ_MUL_EN
         acc_hi_q    <= acc_hi_d;
         acc_lo_q    <= acc_lo_d;
         cnt_q       <= cnt_d;
`endif
      end
   end

   assign in_ready  = (state_q == S_IDLE) & rst_n;
   assign busy      = (state_q != S_IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_res   = rsp_res_q;
   assign rsp_cout  = rsp_cout_q;
   assign rsp_err   = rsp_err_q;
   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_s     = alu_s_q;
   assign alu_m     = alu_m_q;
   assign alu_cin   = alu_cin_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a behavioural 74181-style ALU
// (active-low carries). MUL16 vectors apply when ALU_SEQ_MUL_EN is defined.
module tb_alu_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_op;
   logic [31:0] in_a, in_b;
   logic [3:0]  in_s;
   logic        in_m, in_cin;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_res;
   logic        rsp_cout, rsp_err, busy;
   logic [15:0] alu_a, alu_b, alu_o;
   logic [3:0]  alu_s;
   logic        alu_m, alu_cin, alu_cout;
   logic [16:0] alu_sum;

   int vectors = 0;
   int errs    = 0;
   int lat;

   always #5 clk = ~clk;

   alu_seq_ctrl #(.ADD_S(4'b1001), .CARRY_LOW(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_a(in_a), .in_b(in_b), .in_s(in_s), .in_m(in_m), .in_cin(in_cin),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_res(rsp_res),
      .rsp_cout(rsp_cout), .rsp_err(rsp_err), .busy(busy),
      .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m),
      .alu_cin(alu_cin), .alu_o(alu_o), .alu_cout(alu_cout)
   );

   // 74181-style ALU, active-high data, active-low carry in/out
   always_comb begin
      alu_sum  = 17'h0;
      alu_o    = 16'h0;
      alu_cout = 1'b1;
      if (alu_m) begin
         case (alu_s)
            4'b0110: alu_o = alu_a ^ alu_b;
            4'b1011: alu_o = alu_a & alu_b;
            4'b1110: alu_o = alu_a | alu_b;
            4'b1111: alu_o = alu_a;
            default: alu_o = ~alu_a;
         endcase
      end else begin
         if (alu_s == 4'b1001)
            alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {16'h0, ~alu_cin};
         else
            alu_sum = {1'b0, alu_a} + {16'h0, ~alu_cin};
         alu_o    = alu_sum[15:0];
         alu_cout = ~alu_sum[16];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] s,
                        input logic m, input logic ci);
      @(negedge clk);
      check("in_ready_idle", {31'h0, in_ready}, 32'h1);
      in_valid = 1'b1;
      in_op    = op;
      in_a     = a;
      in_b     = b;
      in_s     = s;
      in_m     = m;
      in_cin   = ci;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int n);
      n = 0;
      while (!rsp_valid && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("rsp_valid_seen", {31'h0, rsp_valid}, 32'h1);
   endtask

   task automatic take();
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      check("rsp_valid_drop", {31'h0, rsp_valid}, 32'h0);
      check("in_ready_back", {31'h0, in_ready}, 32'h1);
   endtask

   task automatic expect_rsp(input string tag, input int exp_lat,
                             input logic [31:0] res, input logic co,
                             input logic er);
      wait_rsp(lat);
      check({tag, "_lat"}, lat, exp_lat);
      check({tag, "_res"}, rsp_res, res);
      check({tag, "_cout"}, {31'h0, rsp_cout}, {31'h0, co});
      check({tag, "_err"}, {31'h0, rsp_err}, {31'h0, er});
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_op     = 2'b00;
      in_a      = 32'h0;
      in_b      = 32'h0;
      in_s      = 4'h0;
      in_m      = 1'b0;
      in_cin    = 1'b0;
      rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      check("rst_busy", {31'h0, busy}, 32'h0);
      check("rst_rsp_res", rsp_res, 32'h0);
      check("rst_flags", {30'h0, rsp_cout, rsp_err}, 32'h0);
      check("rst_alu", {alu_a, alu_s, alu_m, alu_cin, 10'h0}, 32'h0);
      check("rst_in_ready", {31'h0, in_ready}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // ADD32 carry across halves
      issue(2'b01, 32'h0000FFFF, 32'h00000001, 4'h0, 1'b0, 1'b0);
      check("add_busy", {31'h0, busy}, 32'h1);
      check("add_in_ready", {31'h0, in_ready}, 32'h0);
      expect_rsp("add_basic", 2, 32'h00010000, 1'b0, 1'b0);
      take();

      issue(2'b01, 32'hFFFFFFFF, 32'h00000001, 4'h0, 1'b0, 1'b0);
      expect_rsp("add_wrap", 2, 32'h00000000, 1'b1, 1'b0);
      take();

      // op 00 XOR with backpressure and a pending command held off
      issue(2'b00, 32'h000000FF, 32'h00000F0F, 4'b0110, 1'b1, 1'b1);
      expect_rsp("xor", 1, 32'h00000FF0, 1'b1, 1'b0);
      in_valid = 1'b1;
      in_op    = 2'b01;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("bp_valid", {31'h0, rsp_valid}, 32'h1);
         check("bp_res", rsp_res, 32'h00000FF0);
         check("bp_in_ready", {31'h0, in_ready}, 32'h0);
      end
      take();
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("no_turnaround", {31'h0, busy}, 32'h0);

      // op 00 arithmetic, raw active-low carry-in asserted
      issue(2'b00, 32'h0000FFFF, 32'h00000001, 4'b1001, 1'b0, 1'b0);
      expect_rsp("raw_add", 1, 32'h00000001, 1'b0, 1'b0);
      take();

      issue(2'b11, 32'h12345678, 32'h9ABCDEF0, 4'h0, 1'b0, 1'b0);
      expect_rsp("op11", 0, 32'h0, 1'b0, 1'b1);
      take();
      issue(2'b00, 32'h000000FF, 32'h00000F0F, 4'b0110, 1'b1, 1'b1);
      expect_rsp("after_err", 1, 32'h00000FF0, 1'b1, 1'b0);
      take();

`ifdef ALU_SEQ_MUL_EN
      issue(2'b10, 32'h0000FFFF, 32'h0000FFFF, 4'h0, 1'b0, 1'b0);
      expect_rsp("mul_ffff", 16, 32'hFFFE0001, 1'b0, 1'b0);
      take();
      issue(2'b10, 32'h00001234, 32'h00000000, 4'h0, 1'b0, 1'b0);
      expect_rsp("mul_zero", 16, 32'h00000000, 1'b0, 1'b0);
      take();
      issue(2'b10, 32'h00001234, 32'h00000010, 4'h0, 1'b0, 1'b0);
      expect_rsp("mul_x10", 16, 32'h00012340, 1'b0, 1'b0);
      take();
      // abort during the 7th MUL cycle
      issue(2'b10, 32'h00000003, 32'h00000005, 4'h0, 1'b0, 1'b0);
      repeat (6) @(posedge clk);
`else
      issue(2'b10, 32'h0000FFFF, 32'h0000FFFF, 4'h0, 1'b0, 1'b0);
      expect_rsp("op10_off", 0, 32'h0, 1'b0, 1'b1);
      take();
      issue(2'b01, 32'h00000001, 32'h00000002, 4'h0, 1'b0, 1'b0);
      expect_rsp("after_op10", 2, 32'h00000003, 1'b0, 1'b0);
      take();
      // abort an ADD32 between its two passes
      issue(2'b01, 32'h0000FFFF, 32'h00000001, 4'h0, 1'b0, 1'b0);
`endif
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("abort_busy", {31'h0, busy}, 32'h0);
      check("abort_in_ready", {31'h0, in_ready}, 32'h1);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         check("abort_no_rsp", {31'h0, rsp_valid}, 32'h0);
      end

      issue(2'b01, 32'h12345678, 32'h0F0F0F0F, 4'h0, 1'b0, 1'b0);
      expect_rsp("add_after_abort", 2, 32'h21436587, 1'b0, 1'b0);
      take();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
